wshb_stream_responder: RTL

Wishbone slave answering the video-stream read port that `hw_support` drives as master (`wshb_if_stream`), replacing the constant-ack neutralisation in `Top`. It serves one 32-bit pixel word per beat. Pixels come from a deterministic address-derived test pattern, so the video chain can be brought up before the SDRAM framebuffer path exists. It supports classic single reads and incrementing bursts, inserts programmable wait states, flags illegal accesses with `err`, and pulses a flag when the last pixel of a frame is served.

---
 rtl/video_pkg.sv | 24 ++
 rtl/wshb_if.sv | 22 ++
 rtl/wshb_stream_responder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared video definitions: default raster size, stream-responder state
// encoding and the address-derived test-pattern pixel.
package video_pkg;

   localparam int DEF_HDISP = 800;
   localparam int DEF_VDISP = 480;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP,
      BURST
   } stream_state_t;

   // {0, R, G, B} with R/G/B taken from successive index bytes.
   function automatic logic [31:0] pattern_word(input logic [23:0] idx);
      return {8'h00, idx[7:0], idx[15:8], idx[23:16]};
   endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle with master and slave views.
interface wshb_if #(
   parameter int DATA_BYTES = 4
) ();
   logic                    cyc;
   logic                    stb;
   logic                    we;
   logic [31:0]             adr;
   logic [DATA_BYTES-1:0]   sel;
   logic [2:0]              cti;
   logic [1:0]              bte;
   logic [8*DATA_BYTES-1:0] dat_ms;
   logic [8*DATA_BYTES-1:0] dat_sm;
   logic                    ack;
   logic                    err;
   logic                    rty;

   modport master (output cyc, stb, we, adr, sel, cti, bte, dat_ms,
                   input  ack, err, rty, dat_sm);
   modport slave  (input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
                   output ack, err, rty, dat_sm);
endinterface

// File: rtl/wshb_stream_responder.sv
// Wishbone read slave serving a test-pattern pixel per beat, with classic
// and incrementing-burst cycles, wait states, error flagging and frame end pulse.
module wshb_stream_responder
   import video_pkg::*;
#(
   parameter int HDISP       = DEF_HDISP,
   parameter int VDISP       = DEF_VDISP,
   parameter int WAIT_STATES = 1
) (
   input  logic  sys_clk,
   input  logic  sys_rst,
   wshb_if.slave wshb_ifs,
   output logic  frame_done
);

   localparam logic [31:0] NPIX     = 32'(HDISP * VDISP);
   localparam logic [29:0] LAST_IDX = 30'(HDISP * VDISP - 1);
   localparam logic [3:0]  WS_LOAD  = 4'(WAIT_STATES - 1);

   stream_state_t state_q, state_d;
   logic [3:0]    wait_q, wait_d;
   logic [29:0]   nxt_q, nxt_d;
   logic [2:0]    cti_q, cti_d;
   logic          we_q, we_d;
   logic          last_q, last_d;
   logic          ack_q, ack_d;
   logic          err_q, err_d;
   logic          fd_q, fd_d;
   logic [31:0]   dat_q, dat_d;

   logic          rsp_go;
   logic          bst_smp;
   logic [29:0]   r_idx;
   logic          r_we;
   logic          r_legal;

   logic unused_in;
   assign unused_in = ^{wshb_ifs.sel, wshb_ifs.bte, wshb_ifs.adr[1:0], wshb_ifs.dat_ms};

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q <= IDLE;
         wait_q  <= '0;
         nxt_q   <= '0;
         cti_q   <= CTI_CLASSIC;
         we_q    <= 1'b0;
         last_q  <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         fd_q    <= 1'b0;
         dat_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         nxt_q   <= nxt_d;
         cti_q   <= cti_d;
         we_q    <= we_d;
         last_q  <= last_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         fd_q    <= fd_d;
         dat_q   <= dat_d;
      end
   end

   // rsp_go: classic-latency response issued at this edge;
   // bst_smp: this edge samples a burst beat (ack lands in the next cycle).
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      rsp_go  = 1'b0;
      bst_smp = 1'b0;
      if (!wshb_ifs.cyc) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (wshb_ifs.stb) begin
                  if (WAIT_STATES == 0) begin
                     state_d = RESP;
                     rsp_go  = 1'b1;
                  end else begin
                     state_d = WAIT;
                     wait_d  = WS_LOAD;
                  end
               end
            end
            WAIT: begin
               if (wait_q == 4'd0) begin
                  state_d = RESP;
                  rsp_go  = 1'b1;
               end else begin
                  wait_d = wait_q - 4'd1;
               end
            end
            RESP: begin
               if (cti_q == CTI_INC && ack_q) begin
                  state_d = BURST;
                  bst_smp = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            BURST: begin
               if (last_q) state_d = IDLE;
               else        bst_smp = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // First beat addresses come from the live bus in IDLE, later ones from the counter.
   always_comb begin
      r_idx   = (state_q == IDLE) ? wshb_ifs.adr[31:2] : nxt_q;
      r_we    = (state_q == WAIT) ? we_q : wshb_ifs.we;
      r_legal = {2'b00, r_idx} < NPIX;
   end

   always_comb begin
      ack_d  = 1'b0;
      err_d  = 1'b0;
      fd_d   = 1'b0;
      dat_d  = dat_q;
      nxt_d  = nxt_q;
      cti_d  = cti_q;
      we_d   = we_q;
      last_d = last_q;
      if (state_q == IDLE && wshb_ifs.cyc && wshb_ifs.stb) begin
         nxt_d  = wshb_ifs.adr[31:2];
         cti_d  = wshb_ifs.cti;
         we_d   = wshb_ifs.we;
         last_d = 1'b0;
      end
      if (rsp_go || (bst_smp && wshb_ifs.stb)) begin
         dat_d = pattern_word(r_idx[23:0]);
         if (r_we || !r_legal) begin
            err_d = 1'b1;
         end else begin
            ack_d = 1'b1;
            fd_d  = (r_idx == LAST_IDX);
            nxt_d = r_idx + 30'd1;
         end
         if (bst_smp) last_d = (wshb_ifs.cti == CTI_END) || r_we || !r_legal;
      end
   end

   assign wshb_ifs.ack    = ack_q;
   assign wshb_ifs.err    = err_q;
   assign wshb_ifs.rty    = 1'b0;
   assign wshb_ifs.dat_sm = dat_q;
   assign frame_done      = fd_q;

endmodule
